// File: rtl/sync_fifo_pkg.sv
// sync_fifo_pkg: shared types and parameter checks for the sync FIFO read side
package sync_fifo_pkg;
  typedef enum logic [1:0] {IDLE, BURST, DRAIN} burst_rd_state_e;
  function automatic bit params_ok(int burst_len, int timeout_cycles);
    return burst_len >= 1 && timeout_cycles >= 1;
  endfunction
endpackage

// File: rtl/sync_fifo_out_reg.sv
// sync_fifo_out_reg: registered valid/data/last output stage for the burst reader
// load_i/data_i/last_i: capture a popped word; accept_i: consumer ready; valid_o/data_o/last_o: stream outputs
module sync_fifo_out_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
  input  logic         last_i,
  input  logic         accept_i,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o
);
  logic         valid_q, valid_d, last_q, last_d, acc;
  logic [W-1:0] data_q, data_d;
  always_comb begin
    acc     = valid_q && accept_i;
    valid_d = load_i || (valid_q && !acc);
    data_d  = load_i ? data_i : data_q;
    last_d  = load_i ? last_i : (last_q && !acc);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
endmodule

// File: rtl/sync_fifo_burst_reader.sv
// sync_fifo_burst_reader: drains a show-ahead FIFO into bounded valid/ready bursts with an end marker
// FIFO side: fifo_rden, fifo_rddata, fifo_empty, fifo_almost_empty; control: flush, burst_active
// stream side: m_valid, m_data, m_last, m_ready
module sync_fifo_burst_reader
  import sync_fifo_pkg::*;
#(
  parameter int FIFO_WIDTH     = 8,
  parameter int BURST_LEN      = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  fifo_rden,
  input  logic [FIFO_WIDTH-1:0] fifo_rddata,
  input  logic                  fifo_empty,
  input  logic                  fifo_almost_empty,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  burst_active
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  if (!params_ok(BURST_LEN, TIMEOUT_CYCLES)) begin : g_bad_params
    $error("sync_fifo_burst_reader: BURST_LEN and TIMEOUT_CYCLES must be >= 1");
  end
  burst_rd_state_e state_q, state_d;
  logic [BW-1:0]   beat_cnt_q, beat_cnt_d;
  logic [CW-1:0]   idle_cnt_q, idle_cnt_d;
  logic            burst_active_q, go, last_pop;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      beat_cnt_q     <= '0;
      idle_cnt_q     <= '0;
      burst_active_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      beat_cnt_q     <= beat_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      burst_active_q <= state_d != IDLE;
    end
  end
  // a lone word waits for a partner until the idle timer expires or flush forces it out
  always_comb begin
    go         = !fifo_empty && (!fifo_almost_empty || idle_cnt_q == CW'(TIMEOUT_CYCLES - 1) || flush);
    state_d    = state_q == IDLE  ? (go ? BURST : IDLE) :
                 state_q == BURST ? (fifo_rden && last_pop ? DRAIN : BURST) :
                                    (!m_valid || m_ready ? IDLE : DRAIN);
    idle_cnt_d = state_q == IDLE && !fifo_empty && !go ? idle_cnt_q + CW'(1) : '0;
    beat_cnt_d = state_q == BURST ? beat_cnt_q + BW'(fifo_rden) : '0;
  end
  // popping the sole entry ends the burst, so a word written in that same cycle opens the next one
  always_comb begin
    fifo_rden    = !rst && state_q == BURST && !fifo_empty && (!m_valid || m_ready);
    last_pop     = beat_cnt_q == BW'(BURST_LEN - 1) || fifo_almost_empty;
    burst_active = burst_active_q;
  end
  sync_fifo_out_reg #(.W(FIFO_WIDTH)) u_out_reg (
    .clk      (clk),
    .rst      (rst),
    .load_i   (fifo_rden),
    .data_i   (fifo_rddata),
    .last_i   (last_pop),
    .accept_i (m_ready),
    .valid_o  (m_valid),
    .data_o   (m_data),
    .last_o   (m_last)
  );
endmodule

// File: tb/tb_sync_fifo_burst_reader.sv
// tb_sync_fifo_burst_reader: scoreboard bench for the FIFO burst reader with a behavioural FIFO
module tb_sync_fifo_burst_reader;
  typedef struct {logic [7:0] d; logic l;} exp_t;
  logic clk = 1'b0;
  logic rst, fifo_rden, fifo_empty, fifo_almost_empty, flush;
  logic m_valid, m_last, m_ready, burst_active;
  logic [7:0] fifo_rddata, m_data;
  logic wr_en, fclr;
  logic [7:0] wr_data;
  logic [7:0] mem [16];
  logic [3:0] wp, rp;
  logic [4:0] cnt;
  exp_t sb[$];
  int n_vec = 0, n_err = 0, n_acc = 0;
  logic stall_q = 1'b0, gap_q = 1'b0;
  logic [7:0] stall_d;
  always #5 clk = ~clk;
  sync_fifo_burst_reader #(.FIFO_WIDTH(8), .BURST_LEN(4), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .fifo_rden(fifo_rden), .fifo_rddata(fifo_rddata),
    .fifo_empty(fifo_empty), .fifo_almost_empty(fifo_almost_empty), .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .burst_active(burst_active)
  );
  always @(posedge clk) begin
    if (fclr) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
    end else begin
      if (wr_en) begin
        mem[wp] <= wr_data;
        wp <= wp + 4'd1;
      end
      if (fifo_rden && cnt != 0) rp <= rp + 4'd1;
      cnt <= cnt + 5'(wr_en) - 5'(fifo_rden && cnt != 0);
    end
  end
  assign fifo_empty = cnt == 0;
  assign fifo_almost_empty = cnt <= 1;
  assign fifo_rddata = mem[rp];
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rden && fifo_empty) begin
        n_err++;
        $display("FAIL rden_empty: fifo_rden=1 while fifo_empty=1 at %0t", $time);
      end
      if (fifo_rden && m_valid && !m_ready) begin
        n_err++;
        $display("FAIL stall_pop: fifo_rden=1 while stalled at %0t", $time);
      end
      if (stall_q && (!m_valid || m_data !== stall_d)) begin
        n_err++;
        $display("FAIL stall_hold: got valid=%0b data=%h expected valid=1 data=%h", m_valid, m_data, stall_d);
      end
      if (gap_q) begin
        n_vec++;
        if (m_valid) begin
          n_err++;
          $display("FAIL burst_gap: got m_valid=1 expected 0 after last accept at %0t", $time);
        end
      end
      if (m_valid && m_ready) begin
        n_acc++;
        n_vec++;
        if (sb.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: got data=%h last=%0b expected no beat", m_data, m_last);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (m_data !== e.d || m_last !== e.l) begin
            n_err++;
            $display("FAIL beat: got data=%h last=%0b expected data=%h last=%0b", m_data, m_last, e.d, e.l);
          end
        end
      end
    end
    stall_q = !rst && m_valid && !m_ready;
    stall_d = m_data;
    gap_q = !rst && m_valid && m_ready && m_last;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic write(input logic [7:0] d);
    wr_en = 1'b1;
    wr_data = d;
    tick();
    wr_en = 1'b0;
  endtask
  task automatic push(input logic [7:0] d, input logic l);
    sb.push_back('{d, l});
  endtask
  task automatic wait_done(input string nm);
    int k;
    for (k = 0; k < 100 && (sb.size() != 0 || burst_active || m_valid); k++) tick();
    chk(nm, 32'(k < 100), 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int k;
    logic [11:0] pat;
    logic act;
    rst = 1'b1; fclr = 1'b1; wr_en = 1'b0; wr_data = '0; flush = 1'b0; m_ready = 1'b1;
    tick();
    fclr = 1'b0;
    write(8'h01);
    write(8'h02);
    chk("rst_rden", 32'(fifo_rden), 0);
    chk("rst_valid", 32'(m_valid), 0);
    chk("rst_data", 32'(m_data), 0);
    chk("rst_last", 32'(m_last), 0);
    chk("rst_active", 32'(burst_active), 0);
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(8'(8'h10 + i), i == 3 || i == 5);
      write(8'(8'h10 + i));
    end
    rst = 1'b0;
    for (k = 0; k < 40 && !m_valid; k++) tick();
    chk("two_start", 32'(k), 2);
    for (int i = 0; i < 12; i++) begin
      pat[i] = m_valid;
      tick();
    end
    chk("two_pattern", 32'(pat), 32'h0CF);
    wait_done("two_done");
    push(8'hA5, 1'b1);
    write(8'hA5);
    chk("to_empty_fell", 32'(fifo_empty), 0);
    for (k = 0; k < 40 && !m_valid; k++) tick();
    chk("timeout_latency", 32'(k), 17);
    chk("timeout_last", 32'(m_last), 1);
    wait_done("timeout_done");
    push(8'h3C, 1'b1);
    write(8'h3C);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    for (k = 1; k < 40 && !m_valid; k++) tick();
    chk("flush_latency", 32'(k), 2);
    chk("flush_last", 32'(m_last), 1);
    wait_done("flush_done");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    act = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (burst_active || m_valid || fifo_rden) act = 1'b1;
      tick();
    end
    chk("flush_empty_idle", 32'(act), 0);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h40 + i), i == 3);
      write(8'(8'h40 + i));
    end
    n_acc = 0;
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      m_ready = !i[0];
      tick();
    end
    m_ready = 1'b1;
    wait_done("bp_done");
    chk("bp_beats", 32'(n_acc), 4);
    n_acc = 0;
    for (int i = 0; i < 8; i++) push(8'(8'h60 + i), i == 3 || i == 7);
    for (int i = 0; i < 8; i++) write(8'(8'h60 + i));
    wait_done("conc_done");
    chk("conc_beats", 32'(n_acc), 8);
    rst = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      push(8'(8'h50 + i), i == 3);
      write(8'(8'h50 + i));
    end
    rst = 1'b0;
    for (k = 0; k < 40 && !m_valid; k++) tick();
    chk("rmid_start", 32'(k), 2);
    tick();
    rst = 1'b1;
    tick();
    chk("rmid_valid", 32'(m_valid), 0);
    chk("rmid_data", 32'(m_data), 0);
    chk("rmid_last", 32'(m_last), 0);
    chk("rmid_active", 32'(burst_active), 0);
    chk("rmid_rden", 32'(fifo_rden), 0);
    sb.delete();
    fclr = 1'b1;
    tick();
    fclr = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
